// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, response and RAM-port signals shared by the arbiter and its requesters/RAM.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic        datomic;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: registered-grant arbiter sharing one RAM port, data first with bounded instruction starvation.
// Define LLSC_EN to add the LL/SC link register; without it datomic is ignored.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input logic         CLK,
    input logic         nRST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    state_t     state, state_n;
    logic [3:0] scnt;
    logic       dreq, access, d_done, sc, sc_fail;

    assign dreq   = bus.dREN | bus.dWEN;
    assign access = bus.ramstate == 2'd2;
    assign d_done = (state == DGNT) & dreq & access;

`ifdef LLSC_EN
    logic [31:0] linkaddr;
    logic        linkvalid;
    assign sc      = bus.dWEN & bus.datomic;
    // A doomed SC is answered from IDLE without touching the RAM; reset masks it off.
    assign sc_fail = nRST & (state == IDLE) & sc & ~(linkvalid & (bus.daddr == linkaddr));
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            linkaddr  <= 32'd0;
            linkvalid <= 1'b0;
        end else if (d_done) begin
            if (bus.dWEN) begin
                if (bus.datomic || bus.daddr == linkaddr) linkvalid <= 1'b0;
            end else if (bus.datomic) begin
                linkaddr  <= bus.daddr;
                linkvalid <= 1'b1;
            end
        end
    end
`else
    logic unused_datomic;
    assign unused_datomic = bus.datomic;
    assign sc      = 1'b0;
    assign sc_fail = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) scnt <= 4'd0;
        else if (!bus.iREN || (state == IDLE && state_n == IGNT)) scnt <= 4'd0;
        else if (d_done && scnt < 4'(STARVE_MAX)) scnt <= scnt + 4'd1;
    end

    always_comb begin
        state_n      = state;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'd0;
        bus.ramstore = 32'd0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = 32'd0;
        bus.dload    = 32'd0;
        case (state)
            IDLE: begin
                bus.dwait = ~sc_fail;
                state_n   = sc_fail ? IDLE :
                            (dreq && (!bus.iREN || scnt < 4'(STARVE_MAX))) ? DGNT :
                            bus.iREN ? IGNT : IDLE;
            end
            IGNT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = ~(bus.iREN & access);
                bus.iload   = (bus.iREN & access) ? bus.ramload : 32'd0;
                state_n     = (!bus.iREN || access) ? IDLE : IGNT;
            end
            DGNT: begin
                // Enables follow the live request so an abandoned access stops at once.
                bus.ramaddr  = bus.daddr;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramstore = bus.dWEN ? bus.dstore : 32'd0;
                bus.dwait    = ~d_done;
                bus.dload    = !d_done ? 32'd0 : bus.dWEN ? {31'd0, sc} : bus.ramload;
                state_n      = (!dreq || access) ? IDLE : DGNT;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-programmable RAM model.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus();
    mem_arbiter #(.STARVE_MAX(4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

`ifdef LLSC_EN
    localparam bit LL = 1'b1;
`else
    localparam bit LL = 1'b0;
`endif

    typedef struct packed {
        logic        d;
        logic [31:0] load;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0, dlow = 0, wen_cyc = 0;
    int          rcnt = 0, busy_n = 0;
    bit          err_mode = 1'b0;
    logic [31:0] mem [256];

    // RAM answers ACCESS after busy_n BUSY (or ERROR) cycles of continuous enable.
    assign bus.ramstate = (bus.ramREN | bus.ramWEN) ?
                          ((rcnt < busy_n) ? (err_mode ? 2'd3 : 2'd1) : 2'd2) : 2'd0;
    assign bus.ramload  = mem[bus.ramaddr[9:2]];

    always @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
            mem[16]  <= 32'h8C220004;
            mem[64]  <= 32'h12345678;
            mem[128] <= 32'h000000AB;
            rcnt     <= 0;
        end else begin
            rcnt <= (!(bus.ramREN | bus.ramWEN) || bus.ramstate == 2'd2) ? 0 : rcnt + 1;
            if (bus.ramWEN && bus.ramstate == 2'd2) mem[bus.ramaddr[9:2]] <= bus.ramstore;
        end
    end

    initial begin
        exp_t e, a;
        forever begin
            @(negedge CLK);
            if (nRST) begin
                checks++;
                if (bus.ramREN && bus.ramWEN) begin
                    errors++;
                    $display("FAIL ram_enables got ramREN=1 ramWEN=1 expected at most one");
                end
                if (!bus.iwait && !bus.dwait) begin
                    errors++;
                    $display("FAIL wait_exclusive got iwait=0 dwait=0 expected at most one low");
                end
                if (!bus.dwait) dlow++;
                if (bus.ramWEN) wen_cyc++;
                if (!bus.iwait || !bus.dwait) begin
                    a.d    = !bus.dwait;
                    a.load = bus.dwait ? bus.iload : bus.dload;
                    a.addr = bus.ramaddr;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_completion got d=%0d load=%h addr=%h expected none", a.d, a.load, a.addr);
                    end else begin
                        e = sb.pop_front();
                        if (a !== e) begin
                            errors++;
                            $display("FAIL completion got d=%0d load=%h addr=%h expected d=%0d load=%h addr=%h",
                                     a.d, a.load, a.addr, e.d, e.load, e.addr);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no finish expected finish before 100000");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input bit d, input logic [31:0] load, input logic [31:0] addr);
        exp_t e;
        e.d = d; e.load = load; e.addr = addr;
        sb.push_back(e);
    endtask

    task automatic req(input bit d, input bit wr, input bit at, input logic [31:0] addr,
                       input logic [31:0] st, output int lat);
        bit done = 1'b0;
        lat = 0;
        if (d) begin
            bus.dREN = !wr; bus.dWEN = wr; bus.datomic = at; bus.daddr = addr; bus.dstore = st;
        end else begin
            bus.iREN = 1'b1; bus.iaddr = addr;
        end
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge CLK);
            lat++;
            done = d ? !bus.dwait : !bus.iwait;
        end
        if (!done) begin
            errors++;
            $display("FAIL req_timeout got no completion expected one for side %0d", d);
        end
        @(posedge CLK); #1;
        if (d) begin
            bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.datomic = 1'b0;
        end else bus.iREN = 1'b0;
    endtask

    initial begin
        int lat, lat2, d0, w0;
        bit done;
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.datomic = 0; bus.daddr = 0; bus.dstore = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ramREN", 32'(bus.ramREN), 0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_iwait", 32'(bus.iwait), 1);
        chk("rst_dwait", 32'(bus.dwait), 1);
        chk("rst_iload", bus.iload, 0);
        chk("rst_dload", bus.dload, 0);
        nRST = 1'b1;

        push(0, 32'h8C220004, 32'h40);
        req(0, 0, 0, 32'h40, 0, lat);
        chk("ifetch_latency", lat, 2);

        push(1, 32'h12345678, 32'h100);
        push(0, 32'h8C220004, 32'h40);
        fork
            req(1, 0, 0, 32'h100, 0, lat);
            req(0, 0, 0, 32'h40, 0, lat2);
        join
        chk("simul_data_latency", lat, 2);
        chk("simul_inst_latency", lat2, 4);

        repeat (4) push(1, 0, 32'h300);
        push(0, 32'h8C220004, 32'h40);
        bus.iREN = 1; bus.iaddr = 32'h40;
        bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = 32'h77;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge CLK);
            done = !bus.iwait;
        end
        if (!done) begin
            errors++;
            $display("FAIL starve_timeout got no instruction grant expected one after 4 writes");
        end
        @(posedge CLK); #1;
        bus.iREN = 0; bus.dWEN = 0;
        chk("starve_sb_empty", sb.size(), 0);
        chk("starve_scnt", 32'(dut.scnt), 0);
        chk("starve_mem", mem[192], 32'h77);

        busy_n = 3; err_mode = 1'b1; d0 = dlow;
        push(1, 32'h12345678, 32'h100);
        req(1, 0, 0, 32'h100, 0, lat);
        chk("retry_latency", lat, 5);
        chk("retry_dwait_cycles", dlow - d0, 1);
        busy_n = 20; err_mode = 1'b0; d0 = dlow;

        bus.dREN = 1; bus.daddr = 32'h100;
        @(negedge CLK);
        @(negedge CLK);
        chk("abort_granted_ramREN", 32'(bus.ramREN), 1);
        @(posedge CLK); #1;
        bus.dREN = 0;
        #1;
        chk("abort_drop_ramREN", 32'(bus.ramREN), 0);
        @(negedge CLK);
        @(negedge CLK);
        chk("abort_idle_ramaddr", bus.ramaddr, 0);
        chk("abort_dwait_cycles", dlow - d0, 0);
        @(posedge CLK); #1;

        bus.iREN = 1; bus.iaddr = 32'h40;
        @(negedge CLK);
        @(negedge CLK);
        chk("rstmid_granted_ramREN", 32'(bus.ramREN), 1);
        #2 nRST = 1'b0;
        #1;
        chk("rstmid_ramREN", 32'(bus.ramREN), 0);
        chk("rstmid_iwait", 32'(bus.iwait), 1);
        chk("rstmid_ramaddr", bus.ramaddr, 0);
        @(posedge CLK); #1;
        busy_n = 0;
        nRST = 1'b1;
        @(negedge CLK);
        chk("rstmid_idle_ramREN", 32'(bus.ramREN), 0);
        chk("rstmid_idle_ramaddr", bus.ramaddr, 0);
        bus.iREN = 0;
        @(posedge CLK); #1;
        push(0, 32'h8C220004, 32'h40);
        req(0, 0, 0, 32'h40, 0, lat);
        chk("post_reset_latency", lat, 2);

        push(1, 32'hAB, 32'h200);
        req(1, 0, 1, 32'h200, 0, lat);
        push(1, {31'd0, LL}, 32'h200);
        req(1, 1, 1, 32'h200, 32'h5, lat);
        chk("sc_latency", lat, 2);
        chk("sc_mem", mem[128], 32'h5);
        w0 = wen_cyc;
        push(1, 0, LL ? 32'h0 : 32'h200);
        req(1, 1, 1, 32'h200, 32'h6, lat);
        chk("sc2_latency", lat, LL ? 1 : 2);
        chk("sc2_wen_cycles", wen_cyc - w0, LL ? 0 : 1);
        chk("sc2_mem", mem[128], LL ? 32'h5 : 32'h6);

        repeat (2) @(posedge CLK);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
